frogger_board: RTL and testbench

- Game-state engine that produces the 8x8 red and green frame arrays consumed directly by the LED matrix driver.
- Red carries traffic lanes.
- Green carries the frog, and a full-board flash on a win.
- Owns lane scrolling, pseudo-random car spawning, frog movement, collision/win detection, lives and score.

---
 rtl/frogger_board.sv | 167 ++++++++++++++++
 tb/tb_frogger_board.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_board.sv
// Frogger game-state engine: lanes, frog, lives and score, decoded into 8x8 red/green frames.
// state | meaning: PLAY = live game | HIT = frog struck, blinking | WIN = crossing done, flash | OVER = no lives left
module frogger_board #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          HOLD_TICKS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            start,
    input  logic            mv_up,
    input  logic            mv_down,
    input  logic            mv_left,
    input  logic            mv_right,
    output logic [7:0][7:0] red_array,
    output logic [7:0][7:0] green_array,
    output logic [1:0]      lives,
    output logic [3:0]      score,
    output logic            game_over
);

    typedef enum logic [1:0] {S_PLAY, S_HIT, S_WIN, S_OVER} state_t;

    localparam logic [6:1][1:0] PERIOD_M1 = {2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
    localparam logic [3:0]      HOLD_LAST = 4'(HOLD_TICKS - 1);

    state_t          state, state_nxt;
    logic [6:1][7:0] lane, lane_nxt, lane_adv;
    logic [6:1][1:0] div_cnt, div_nxt, div_adv;
    logic [3:0]      hold_cnt, hold_nxt;
    logic [15:0]     lfsr, lfsr_nxt;
    logic [2:0]      frog_row, row_nxt;
    logic [2:0]      frog_col, col_nxt;
    logic [1:0]      lives_nxt;
    logic [3:0]      score_nxt;
    logic            blink, blink_nxt;
    logic            lfsr_fb;
    logic            collision;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Entry needs the entry cell and its neighbour empty, keeping cars single and gaps >= 2.
    genvar g;
    for (g = 1; g <= 6; g++) begin : g_lane
        logic wrap;
        assign wrap       = (div_cnt[g] == PERIOD_M1[g]);
        assign div_adv[g] = wrap ? 2'd0 : div_cnt[g] + 2'd1;
        if (g % 2 == 1) begin : g_odd
            assign lane_adv[g] = wrap ? {lane[g][6:0], lfsr[g] & ~lane[g][0] & ~lane[g][1]}
                                      : lane[g];
        end else begin : g_even
            assign lane_adv[g] = wrap ? {lfsr[g] & ~lane[g][7] & ~lane[g][6], lane[g][7:1]}
                                      : lane[g];
        end
    end

    assign red_array = (state == S_OVER) ? '1 : {8'h00, lane, 8'h00};
    assign collision = red_array[frog_row][frog_col];
    assign game_over = (state == S_OVER);

    always_comb begin
        green_array = '0;
        case (state)
            S_PLAY:  green_array[frog_row][frog_col] = 1'b1;
            S_HIT:   green_array[frog_row][frog_col] = blink;
            S_WIN:   green_array = '1;
            default: green_array = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        div_nxt   = div_cnt;
        hold_nxt  = hold_cnt;
        lfsr_nxt  = lfsr;
        row_nxt   = frog_row;
        col_nxt   = frog_col;
        lives_nxt = lives;
        score_nxt = score;
        blink_nxt = blink;

        if (tick && state != S_OVER) begin
            lfsr_nxt = {lfsr[14:0], lfsr_fb};
        end

        case (state)
            S_PLAY: begin
                if (tick) begin
                    lane_nxt = lane_adv;
                    div_nxt  = div_adv;
                end
                if (collision) begin
                    state_nxt = S_HIT;
                    blink_nxt = 1'b1;
                end else if (frog_row == 3'd7) begin
                    state_nxt = S_WIN;
                    if (score != 4'd15) score_nxt = score + 4'd1;
                end else if (mv_up) begin
                    row_nxt = frog_row + 3'd1;
                end else if (mv_down) begin
                    if (frog_row != 3'd0) row_nxt = frog_row - 3'd1;
                end else if (mv_left) begin
                    if (frog_col != 3'd0) col_nxt = frog_col - 3'd1;
                end else if (mv_right) begin
                    if (frog_col != 3'd7) col_nxt = frog_col + 3'd1;
                end
            end
            S_HIT, S_WIN: begin
                if (tick) begin
                    if (state == S_HIT) blink_nxt = ~blink;
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt = 4'd0;
                        row_nxt  = 3'd0;
                        col_nxt  = 3'd3;
                        if (state == S_HIT) begin
                            lives_nxt = lives - 2'd1;
                            state_nxt = (lives == 2'd1) ? S_OVER : S_PLAY;
                        end else begin
                            state_nxt = S_PLAY;
                        end
                    end else begin
                        hold_nxt = hold_cnt + 4'd1;
                    end
                end
            end
            default: begin
                if (start) begin
                    lane_nxt  = '0;
                    div_nxt   = '0;
                    lives_nxt = 2'd3;
                    score_nxt = 4'd0;
                    row_nxt   = 3'd0;
                    col_nxt   = 3'd3;
                    state_nxt = S_PLAY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_PLAY;
            lane     <= '0;
            div_cnt  <= '0;
            hold_cnt <= 4'd0;
            lfsr     <= SEED;
            frog_row <= 3'd0;
            frog_col <= 3'd3;
            lives    <= 2'd3;
            score    <= 4'd0;
            blink    <= 1'b0;
        end else begin
            state    <= state_nxt;
            lane     <= lane_nxt;
            div_cnt  <= div_nxt;
            hold_cnt <= hold_nxt;
            lfsr     <= lfsr_nxt;
            frog_row <= row_nxt;
            frog_col <= col_nxt;
            lives    <= lives_nxt;
            score    <= score_nxt;
            blink    <= blink_nxt;
        end
    end

endmodule

// File: tb/tb_frogger_board.sv
// Scoreboard bench for frogger_board: a cell-level game model predicts every frame and counter.
module tb_frogger_board;

    localparam int HOLD = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            tick = 1'b0;
    logic            start = 1'b0;
    logic            mv_up = 1'b0;
    logic            mv_down = 1'b0;
    logic            mv_left = 1'b0;
    logic            mv_right = 1'b0;
    logic [7:0][7:0] red_array;
    logic [7:0][7:0] green_array;
    logic [1:0]      lives;
    logic [3:0]      score;
    logic            game_over;

    frogger_board dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
        .red_array(red_array), .green_array(green_array),
        .lives(lives), .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] red;
        logic [63:0] green;
        int          lives;
        int          score;
        bit          over;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Game model: mode 0=play 1=hit 2=win 3=over
    int          m_mode;
    bit          m_lane[8][8];
    int          m_cnt[8];
    int          m_hold;
    bit          m_vis;
    int          m_row, m_col, m_lives, m_score;
    int unsigned m_lfsr;
    int          period[8] = '{0, 4, 3, 2, 3, 2, 1, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        foreach (m_lane[r, c]) m_lane[r][c] = 1'b0;
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_hold  = 0;
        m_vis   = 1'b0;
        m_row   = 0;
        m_col   = 3;
        m_lives = 3;
        m_score = 0;
        m_lfsr  = 32'hACE1;
    endtask

    task automatic shift_lane(input int r);
        bit odd, en;
        int e, n;
        odd = (r % 2) == 1;
        e   = odd ? 0 : 7;
        n   = odd ? 1 : 6;
        en  = ((m_lfsr >> r) & 1) == 1 && !m_lane[r][e] && !m_lane[r][n];
        if (odd) begin
            for (int c = 7; c >= 1; c--) m_lane[r][c] = m_lane[r][c-1];
            m_lane[r][0] = en;
        end else begin
            for (int c = 0; c <= 6; c++) m_lane[r][c] = m_lane[r][c+1];
            m_lane[r][7] = en;
        end
    endtask

    task automatic lfsr_step();
        int unsigned fb;
        fb     = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 32'hFFFF;
    endtask

    task automatic model_step();
        bit hit;
        if (!reset) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                hit = m_lane[m_row][m_col];
                if (tick) begin
                    for (int r = 1; r <= 6; r++) begin
                        m_cnt[r]++;
                        if (m_cnt[r] == period[r]) begin
                            m_cnt[r] = 0;
                            shift_lane(r);
                        end
                    end
                    lfsr_step();
                end
                if (hit) begin
                    m_mode = 1;
                    m_vis  = 1'b1;
                end else if (m_row == 7) begin
                    m_mode  = 2;
                    m_score = (m_score < 15) ? m_score + 1 : 15;
                end else if (mv_up) m_row = m_row + 1;
                else if (mv_down) m_row = (m_row > 0) ? m_row - 1 : 0;
                else if (mv_left) m_col = (m_col > 0) ? m_col - 1 : 0;
                else if (mv_right) m_col = (m_col < 7) ? m_col + 1 : 7;
            end
            1, 2: begin
                if (tick) begin
                    lfsr_step();
                    if (m_mode == 1) m_vis = !m_vis;
                    m_hold++;
                    if (m_hold == HOLD) begin
                        m_hold = 0;
                        m_row  = 0;
                        m_col  = 3;
                        if (m_mode == 1) begin
                            m_lives--;
                            m_mode = (m_lives == 0) ? 3 : 0;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    foreach (m_lane[r, c]) m_lane[r][c] = 1'b0;
                    foreach (m_cnt[r]) m_cnt[r] = 0;
                    m_lives = 3;
                    m_score = 0;
                    m_row   = 0;
                    m_col   = 3;
                    m_mode  = 0;
                end
            end
        endcase
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        e.red   = '0;
        e.green = '0;
        if (m_mode == 3) e.red = '1;
        else
            for (int r = 1; r <= 6; r++)
                for (int c = 0; c < 8; c++)
                    e.red[r*8+c] = m_lane[r][c];
        case (m_mode)
            0: e.green[m_row*8+m_col] = 1'b1;
            1: e.green[m_row*8+m_col] = m_vis;
            2: e.green = '1;
            default: e.green = '0;
        endcase
        e.lives = m_lives;
        e.score = m_score;
        e.over  = (m_mode == 3);
        return e;
    endfunction

    // Monitor: every frame the DUT presents is matched against the oldest prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                logic [63:0] r;
                e = q.pop_front();
                r = red_array;
                chk("red", r, e.red);
                chk("green", green_array, e.green);
                chk("lives", 64'(lives), 64'(e.lives));
                chk("score", 64'(score), 64'(e.score));
                chk("game_over", 64'(game_over), 64'(e.over));
                if (!game_over) chk("lane_gap", 64'((r & (r << 1)) & 64'h00FE_FEFE_FEFE_FE00), 64'd0);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        q.push_back(model_expect());
        #1;
    endtask

    task automatic drive(input bit tk, st, u, d, l, r);
        tick = tk; start = st; mv_up = u; mv_down = d; mv_left = l; mv_right = r;
        cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0);
    endtask

    // Reset lands between edges so the immediate effect can be observed.
    task automatic do_reset(input int n);
        tick = 0; start = 0; mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_red", red_array, 64'd0);
        chk("rst_green", green_array, 64'h8);
        chk("rst_lives", 64'(lives), 64'd3);
        chk("rst_score", 64'(score), 64'd0);
        chk("rst_over", 64'(game_over), 64'd0);
        repeat (n) cycle();
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset(3);
        idle(10);

        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            idle(1);
        end

        repeat (5) begin
            drive(0, 0, 0, 0, 1, 0);
            idle(1);
        end
        drive(0, 0, 1, 0, 0, 1);
        idle(1);
        drive(0, 0, 0, 1, 0, 0);
        idle(2);

        do_reset(2);
        repeat (7) begin
            drive(0, 0, 1, 0, 0, 0);
            idle(1);
        end
        idle(2);
        repeat (HOLD) begin
            drive(1, 0, 0, 0, 0, 0);
            idle(1);
        end
        idle(2);

        do_reset(2);
        repeat (7) drive(0, 0, 1, 0, 0, 0);
        idle(3);
        do_reset(2);
        idle(2);

        for (int i = 0; i < 4000; i++) begin
            int  k;
            bit  tk, st;
            k  = $urandom_range(0, 9);
            tk = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 15) == 0);
            case (k)
                0, 1, 2, 3: drive(tk, st, 1, 0, 0, 0);
                4:          drive(tk, st, 0, 1, 0, 0);
                5:          drive(tk, st, 0, 0, 1, 0);
                6:          drive(tk, st, 0, 0, 0, 1);
                7:          drive(tk, st, 1, 0, 0, 1);
                default:    drive(tk, st, 0, 0, 0, 0);
            endcase
        end

        idle(2);
        @(negedge clk);
        #1;
        chk("drain", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
